// File: rtl/div_hilo_ctrl_if.sv
// Request/result bundle for the HI/LO divide controller, plus the operand/result
// connection to the external array divider.
interface div_hilo_ctrl_if;
    logic        start;
    logic        signed_op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [63:0] div_result;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output start, signed_op, a_in, b_in, hi_in, lo_in, hi_we, lo_we, div_result,
        input  div_a, div_b, busy, done, dbz, hi_out, lo_out
    );

    modport slave (
        input  start, signed_op, a_in, b_in, hi_in, lo_in, hi_we, lo_we, div_result,
        output div_a, div_b, busy, done, dbz, hi_out, lo_out
    );
endinterface

// File: rtl/div_hilo_ctrl.sv
// Sequencer for the 32-bit array divider: launches unsigned magnitudes, waits LAT
// settle cycles, applies sign correction and commits remainder/quotient to HI/LO.
module div_hilo_ctrl #(
    parameter int unsigned LAT = 4
) (
    input logic             clk,
    input logic             clr,
    div_hilo_ctrl_if.slave  bus
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] div_a_q, div_a_d;
    logic [31:0] div_b_q, div_b_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic        dbz_q, dbz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        sa, sb;
    logic [31:0] rem_mag, quo_mag;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_a_d  = div_a_q;
        div_b_d  = div_b_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        sa       = bus.signed_op & bus.a_in[31];
        sb       = bus.signed_op & bus.b_in[31];
        // On divide-by-zero, |a| stands in for the remainder so the sign fix restores a_in.
        rem_mag  = dbz_q ? div_a_q : bus.div_result[63:32];
        quo_mag  = bus.div_result[31:0];

        case (state_q)
            StIdle: begin
                if (bus.hi_we) hi_d = bus.hi_in;
                if (bus.lo_we) lo_d = bus.lo_in;
                if (bus.start) begin
                    sign_a_d = sa;
                    sign_b_d = sb;
                    div_a_d  = sa ? -bus.a_in : bus.a_in;
                    div_b_d  = sb ? -bus.b_in : bus.b_in;
                    dbz_d    = (bus.b_in == 32'd0);
                    cnt_d    = (bus.b_in == 32'd0) ? 4'd1 : 4'(LAT);
                    state_d  = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = sign_a_q ? -rem_mag : rem_mag;
                    lo_d    = dbz_q ? 32'hFFFF_FFFF
                                    : ((sign_a_q ^ sign_b_q) ? -quo_mag : quo_mag);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.hi_we) hi_d = bus.hi_in;
                if (bus.lo_we) lo_d = bus.lo_in;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            div_a_q  <= 32'd0;
            div_b_q  <= 32'd0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_a_q  <= div_a_d;
            div_b_q  <= div_b_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.div_a  = div_a_q;
    assign bus.div_b  = div_b_q;
    assign bus.busy   = (state_q == StWait);
    assign bus.done   = (state_q == StDone);
    assign bus.dbz    = dbz_q;
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Directed bench for div_hilo_ctrl; the divider stand-in only returns a valid
// result once its operands have been stable for LAT cycles.
module tb_div_hilo_ctrl;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic clr;
    int   checks = 0;
    int   errors = 0;
    int   n;
    int   done_seen;

    div_hilo_ctrl_if bus ();

    div_hilo_ctrl #(.LAT(LAT)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Divider model: garbage until operands have been seen stable long enough.
    logic [31:0] pa = 32'd0;
    logic [31:0] pb = 32'd0;
    int          age = 0;
    always @(posedge clk) begin
        if (bus.div_a !== pa || bus.div_b !== pb) begin
            pa  <= bus.div_a;
            pb  <= bus.div_b;
            age <= 0;
        end else if (age < 100) begin
            age <= age + 1;
        end
    end
    assign bus.div_result = (age >= LAT - 2 && pb != 32'd0) ? {pa % pb, pa / pb}
                                                             : 64'hA5A5_A5A5_5A5A_5A5A;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic s, input logic [31:0] a, input logic [31:0] b);
        bus.start     = 1'b1;
        bus.signed_op = s;
        bus.a_in      = a;
        bus.b_in      = b;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    // Waits (bounded) for done; leaves the bench at the negedge inside the done cycle.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!bus.done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input logic exp_dbz);
        int c;
        do_start(s, a, b);
        wait_done(c);
        check({tag, " latency"}, 64'(c), (b == 32'd0) ? 64'd1 : 64'(LAT));
        check({tag, " hi"}, 64'(bus.hi_out), 64'(exp_hi));
        check({tag, " lo"}, 64'(bus.lo_out), 64'(exp_lo));
        check({tag, " dbz"}, 64'(bus.dbz), 64'(exp_dbz));
    endtask

    initial begin
        clr           = 1'b0;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.a_in      = 32'd0;
        bus.b_in      = 32'd0;
        bus.hi_in     = 32'd0;
        bus.lo_in     = 32'd0;
        bus.hi_we     = 1'b0;
        bus.lo_we     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset dbz", 64'(bus.dbz), 64'd0);
        check("reset hi", 64'(bus.hi_out), 64'd0);
        check("reset lo", 64'(bus.lo_out), 64'd0);
        check("reset div_a", 64'(bus.div_a), 64'd0);
        clr = 1'b1;
        @(negedge clk);

        // Unsigned 100/7 with cycle-by-cycle timing.
        do_start(1'b0, 32'd100, 32'd7);
        check("u100/7 busy c0", 64'(bus.busy), 64'd1);
        check("u100/7 div_b", 64'(bus.div_b), 64'd7);
        for (int k = 1; k < LAT; k++) begin
            @(negedge clk);
            check("u100/7 busy mid", 64'(bus.busy), 64'd1);
            check("u100/7 done mid", 64'(bus.done), 64'd0);
            check("u100/7 lo early", 64'(bus.lo_out), 64'd0);
        end
        @(negedge clk);
        check("u100/7 done", 64'(bus.done), 64'd1);
        check("u100/7 busy at done", 64'(bus.busy), 64'd0);
        check("u100/7 lo", 64'(bus.lo_out), 64'd14);
        check("u100/7 hi", 64'(bus.hi_out), 64'd2);
        // start during the done cycle must be ignored
        do_start(1'b0, 32'd9, 32'd3);
        check("u100/7 done one cycle", 64'(bus.done), 64'd0);
        check("start in done ignored", 64'(bus.busy), 64'd0);
        @(negedge clk);

        run_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        @(negedge clk);
        run_div("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        @(negedge clk);
        run_div("uFFFFFFF9/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 1'b0);
        @(negedge clk);
        run_div("dbz", 1'b0, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        check("dbz held", 64'(bus.dbz), 64'd1);
        do_start(1'b0, 32'd10, 32'd3);
        check("dbz cleared", 64'(bus.dbz), 64'd0);
        wait_done(n);
        check("u10/3 latency", 64'(n), 64'(LAT));
        check("u10/3 lo", 64'(bus.lo_out), 64'd3);
        check("u10/3 hi", 64'(bus.hi_out), 64'd1);
        @(negedge clk);
        run_div("sdbz neg", 1'b1, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        run_div("smin/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        @(negedge clk);

        // Restart and mthi during WAIT are both ignored.
        do_start(1'b0, 32'd1000, 32'd10);
        n = 0;
        @(negedge clk);
        n++;
        bus.start = 1'b1;
        bus.a_in  = 32'd5;
        bus.b_in  = 32'd1;
        bus.hi_we = 1'b1;
        bus.hi_in = 32'h0000_DEAD;
        @(negedge clk);
        n++;
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        check("restart div_a held", 64'(bus.div_a), 64'd1000);
        check("wait mthi ignored", 64'(bus.hi_out), 64'd0);
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("restart latency", 64'(n), 64'(LAT));
        check("restart lo", 64'(bus.lo_out), 64'h64);
        check("restart hi", 64'(bus.hi_out), 64'd0);
        // mthi in DONE lands after the commit
        bus.hi_we = 1'b1;
        bus.hi_in = 32'h0000_5555;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check("done mthi hi", 64'(bus.hi_out), 64'h5555);
        check("done mthi lo kept", 64'(bus.lo_out), 64'h64);
        // mtlo in IDLE
        bus.lo_we = 1'b1;
        bus.lo_in = 32'h0000_BEEF;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("idle mtlo", 64'(bus.lo_out), 64'hBEEF);

        // Reset mid-divide abandons it.
        do_start(1'b0, 32'd100, 32'd7);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort hi", 64'(bus.hi_out), 64'd0);
        check("abort lo", 64'(bus.lo_out), 64'd0);
        done_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("abort no done", 64'(done_seen), 64'd0);
        run_div("post-abort", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
